// File: rtl/process_scheduler_pkg.sv
// Shared types and constants for the round-robin process scheduler.
package sched_pkg;

    localparam int PID_W       = 3;
    localparam int DEF_NPROC   = 4;
    localparam int DEF_QUANTUM = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SWITCH,
        ST_RUN,
        ST_WAIT_IO,
        ST_DONE
    } sched_state_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY,
        SLOT_READY,
        SLOT_BLOCKED,
        SLOT_EXITED
    } slot_state_e;

    function automatic logic [3:0] clamp_procs(input logic [3:0] n, input int nmax);
        if (int'(n) > nmax) begin
            return 4'(nmax);
        end
        return n;
    endfunction

endpackage

// File: rtl/process_scheduler_if.sv
// Control/status bundle between the CPU/IO side (master) and the scheduler (slave).
interface process_scheduler_if;
    import sched_pkg::*;

    logic             start;
    logic [3:0]       num_procs;
    logic             instr_tick;
    logic             io_req;
    logic             io_done;
    logic [PID_W-1:0] io_pid;
    logic             proc_exit;
    logic             switch_ack;

    logic             switch_req;
    logic [PID_W-1:0] next_pid;
    logic [PID_W-1:0] cur_pid;
    logic             running;
    logic [7:0]       quantum_left;
    logic             all_done;
    logic [15:0]      switch_count;

    modport master (
        output start, num_procs, instr_tick, io_req, io_done, io_pid, proc_exit, switch_ack,
        input  switch_req, next_pid, cur_pid, running, quantum_left, all_done, switch_count
    );

    modport slave (
        input  start, num_procs, instr_tick, io_req, io_done, io_pid, proc_exit, switch_ack,
        output switch_req, next_pid, cur_pid, running, quantum_left, all_done, switch_count
    );

endinterface

// File: rtl/process_scheduler_rr_picker.sv
// Combinational rotating search: first READY slot after last_pid, wrapping modulo NPROC.
module rr_picker
    import sched_pkg::*;
#(
    parameter int NPROC = DEF_NPROC
) (
    input  logic [NPROC-1:0] ready,
    input  logic [PID_W-1:0] last_pid,
    output logic             found,
    output logic [PID_W-1:0] pid
);

    int best;
    int off;

    // Distance from last_pid+1; last_pid itself ends up farthest, so it is chosen only if alone.
    always_comb begin
        best = NPROC;
        off  = 0;
        pid  = '0;
        for (int i = 0; i < NPROC; i++) begin
            off = (i + 2 * NPROC - int'(last_pid) - 1) % NPROC;
            if (ready[i] && off < best) begin
                best = off;
                pid  = PID_W'(i);
            end
        end
        found = (best < NPROC);
    end

endmodule

// File: rtl/process_scheduler.sv
// Round-robin time-slice process scheduler with I/O blocking.
// Optional: define SCHED_STATS_EN to build the saturating context-switch counter.
module process_scheduler
    import sched_pkg::*;
#(
    parameter int NPROC   = DEF_NPROC,
    parameter int QUANTUM = DEF_QUANTUM
) (
    input logic                clk,
    input logic                reset,
    process_scheduler_if.slave bus
);

    localparam logic [PID_W-1:0] LAST_INIT = PID_W'(NPROC - 1);
    localparam logic [7:0]       QUANTUM_L = 8'(QUANTUM);

    sched_state_e     state_q, state_d;
    slot_state_e      slot_q [NPROC];
    slot_state_e      slot_d [NPROC];
    logic [PID_W-1:0] cur_pid_q, cur_pid_d;
    logic [PID_W-1:0] next_pid_q, next_pid_d;
    logic [PID_W-1:0] last_pid_q, last_pid_d;
    logic [7:0]       quantum_q, quantum_d;
    logic             expired_q, expired_d;
    logic             switch_req_q, switch_req_d;
    logic             running_q, running_d;
    logic             all_done_q, all_done_d;

    logic [NPROC-1:0] ready_mask;
    logic             any_blocked;
    logic             io_wake;
    logic             pick_found;
    logic [PID_W-1:0] pick_pid;
    logic             start_accept;
    logic [3:0]       n_eff;

    assign start_accept = (state_q == ST_IDLE) && bus.start && (bus.num_procs != 4'd0);
    assign n_eff        = clamp_procs(bus.num_procs, NPROC);

    always_comb begin
        ready_mask  = '0;
        any_blocked = 1'b0;
        io_wake     = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            ready_mask[i] = (slot_q[i] == SLOT_READY);
            if (slot_q[i] == SLOT_BLOCKED) begin
                any_blocked = 1'b1;
                if (PID_W'(i) == bus.io_pid && bus.io_done && state_q != ST_IDLE) begin
                    io_wake = 1'b1;
                end
            end
        end
    end

    rr_picker #(.NPROC(NPROC)) u_picker (
        .ready    (ready_mask),
        .last_pid (last_pid_q),
        .found    (pick_found),
        .pid      (pick_pid)
    );

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        cur_pid_d  = cur_pid_q;
        next_pid_d = next_pid_q;
        last_pid_d = last_pid_q;
        quantum_d  = quantum_q;
        expired_d  = expired_q;

        // A completed I/O only wakes a slot that is actually blocked.
        if (io_wake) begin
            for (int i = 0; i < NPROC; i++) begin
                if (PID_W'(i) == bus.io_pid) slot_d[i] = SLOT_READY;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    for (int i = 0; i < NPROC; i++) begin
                        slot_d[i] = (4'(i) < n_eff) ? SLOT_READY : SLOT_EMPTY;
                    end
                    last_pid_d = LAST_INIT;
                    expired_d  = 1'b0;
                    state_d    = ST_SELECT;
                end
            end
            ST_SELECT: begin
                expired_d = 1'b0;
                if (pick_found) begin
                    next_pid_d = pick_pid;
                    // Sole runnable process re-selected after its slice: no context switch.
                    if (expired_q && pick_pid == cur_pid_q) begin
                        quantum_d = QUANTUM_L;
                        state_d   = ST_RUN;
                    end else begin
                        state_d = ST_SWITCH;
                    end
                end else if (any_blocked) begin
                    state_d = ST_WAIT_IO;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SWITCH: begin
                if (bus.switch_ack) begin
                    cur_pid_d  = next_pid_q;
                    last_pid_d = next_pid_q;
                    quantum_d  = QUANTUM_L;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.proc_exit) begin
                    for (int i = 0; i < NPROC; i++) begin
                        if (PID_W'(i) == cur_pid_q) slot_d[i] = SLOT_EXITED;
                    end
                    state_d = ST_SELECT;
                end else if (bus.io_req) begin
                    for (int i = 0; i < NPROC; i++) begin
                        if (PID_W'(i) == cur_pid_q) slot_d[i] = SLOT_BLOCKED;
                    end
                    state_d = ST_SELECT;
                end else if (bus.instr_tick) begin
                    quantum_d = quantum_q - 8'd1;
                    if (quantum_q == 8'd1) begin
                        expired_d = 1'b1;
                        state_d   = ST_SELECT;
                    end
                end
            end
            ST_WAIT_IO: begin
                if (io_wake) state_d = ST_SELECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        switch_req_d = (state_d == ST_SWITCH);
        running_d    = (state_d == ST_RUN);
        all_done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            for (int i = 0; i < NPROC; i++) slot_q[i] <= SLOT_EMPTY;
            cur_pid_q    <= '0;
            next_pid_q   <= '0;
            last_pid_q   <= LAST_INIT;
            quantum_q    <= '0;
            expired_q    <= 1'b0;
            switch_req_q <= 1'b0;
            running_q    <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            cur_pid_q    <= cur_pid_d;
            next_pid_q   <= next_pid_d;
            last_pid_q   <= last_pid_d;
            quantum_q    <= quantum_d;
            expired_q    <= expired_d;
            switch_req_q <= switch_req_d;
            running_q    <= running_d;
            all_done_q   <= all_done_d;
        end
    end

`ifdef SCHED_STATS_EN
    logic [15:0] switch_count_q, switch_count_d;

    always_comb begin
        switch_count_d = switch_count_q;
        if (start_accept) begin
            switch_count_d = '0;
        end else if (state_q == ST_SWITCH && bus.switch_ack && switch_count_q != 16'hFFFF) begin
            switch_count_d = switch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) switch_count_q <= '0;
        else       switch_count_q <= switch_count_d;
    end

    assign bus.switch_count = switch_count_q;
`else
    assign bus.switch_count = '0;
`endif

    assign bus.switch_req   = switch_req_q;
    assign bus.next_pid     = next_pid_q;
    assign bus.cur_pid      = cur_pid_q;
    assign bus.running      = running_q;
    assign bus.quantum_left = quantum_q;
    assign bus.all_done     = all_done_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: per-cycle comparison against an event-level model plus directed scenarios.
module tb_process_scheduler;
    import sched_pkg::*;

    localparam int NP = 4;
    localparam int QT = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    process_scheduler_if bus();

    process_scheduler #(.NPROC(NP), .QUANTUM(QT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the scheduler must do at each clock edge.
    localparam int M_IDLE = 0, M_SEL = 1, M_SW = 2, M_RUN = 3, M_WAIT = 4, M_DONE = 5;
    localparam int S_EMPTY = 0, S_READY = 1, S_BLK = 2, S_EXIT = 3;

    int m_mode, m_cur, m_next, m_last, m_q, m_cnt;
    bit m_exp;
    int m_slot [NP];
    int m_order [$];

    task automatic model_reset();
        m_mode = M_IDLE; m_cur = 0; m_next = 0; m_last = NP - 1; m_q = 0; m_cnt = 0; m_exp = 0;
        for (int i = 0; i < NP; i++) m_slot[i] = S_EMPTY;
    endtask

    task automatic model_step();
        bit wake;
        bit found;
        bit anyblk;
        int idx, p, n;
        idx = int'(bus.io_pid);
        wake = (m_mode != M_IDLE) && bus.io_done && (idx < NP) && (m_slot[idx % NP] == S_BLK);
        found = 0; anyblk = 0; p = 0;
        case (m_mode)
            M_IDLE: if (bus.start && bus.num_procs != 0) begin
                n = (int'(bus.num_procs) > NP) ? NP : int'(bus.num_procs);
                for (int i = 0; i < NP; i++) m_slot[i] = (i < n) ? S_READY : S_EMPTY;
                m_last = NP - 1; m_exp = 0; m_cnt = 0; m_mode = M_SEL;
            end
            M_SEL: begin
                for (int k = 1; k <= NP; k++) begin
                    if (!found && m_slot[(m_last + k) % NP] == S_READY) begin
                        found = 1; p = (m_last + k) % NP;
                    end
                end
                for (int i = 0; i < NP; i++) if (m_slot[i] == S_BLK) anyblk = 1;
                if (found) begin
                    m_next = p;
                    if (m_exp && p == m_cur) begin m_q = QT; m_mode = M_RUN; end
                    else m_mode = M_SW;
                end else m_mode = anyblk ? M_WAIT : M_DONE;
                m_exp = 0;
            end
            M_SW: if (bus.switch_ack) begin
                m_cur = m_next; m_last = m_next; m_q = QT; m_mode = M_RUN;
                m_order.push_back(m_next);
`ifdef SCHED_STATS_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
            M_RUN: begin
                if (bus.proc_exit) begin m_slot[m_cur] = S_EXIT; m_mode = M_SEL; end
                else if (bus.io_req) begin m_slot[m_cur] = S_BLK; m_mode = M_SEL; end
                else if (bus.instr_tick) begin
                    m_q--;
                    if (m_q == 0) begin m_exp = 1; m_mode = M_SEL; end
                end
            end
            M_WAIT: if (wake) m_mode = M_SEL;
            default: m_mode = M_IDLE;
        endcase
        if (wake) m_slot[idx % NP] = S_READY;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    always @(negedge clk) begin
        chk("cur_pid", bus.cur_pid, m_cur);
        chk("next_pid", bus.next_pid, m_next);
        chk("switch_req", bus.switch_req, m_mode == M_SW);
        chk("running", bus.running, m_mode == M_RUN);
        chk("quantum_left", bus.quantum_left, m_q);
        chk("all_done", bus.all_done, m_mode == M_DONE);
        chk("switch_count", bus.switch_count, m_cnt);
    end

    // Switch order and slice length as seen on the DUT pins.
    int dut_order [$];
    int q_after [$];
    bit rec_q = 0;
    always @(negedge clk) begin
        if (rec_q) begin q_after.push_back(int'(bus.quantum_left)); rec_q = 0; end
        if (bus.switch_req && bus.switch_ack) begin dut_order.push_back(int'(bus.next_pid)); rec_q = 1; end
    end

    // CPU side: acknowledge each switch request two cycles after it appears.
    bit ack_en = 1;
    initial begin
        int wait_cnt;
        wait_cnt = 0;
        bus.switch_ack = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (bus.switch_ack) begin
                bus.switch_ack = 1'b0; wait_cnt = 0;
            end else if (ack_en && bus.switch_req) begin
                wait_cnt++;
                if (wait_cnt >= 2) bus.switch_ack = 1'b1;
            end else wait_cnt = 0;
        end
    end

    task automatic step();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset = 1'b1; step(); step(); reset = 1'b0; step();
        dut_order.delete(); q_after.delete(); m_order.delete();
    endtask

    task automatic start_procs(input int n);
        bus.num_procs = 4'(n); bus.start = 1'b1; step(); bus.start = 1'b0;
    endtask

    task automatic ticks(input int n);
        bus.instr_tick = 1'b1; repeat (n) step(); bus.instr_tick = 1'b0;
    endtask

    task automatic wait_running(input string name);
        int k;
        k = 0;
        while (!bus.running && k < 100) begin step(); k++; end
        chk(name, bus.running, 1);
    endtask

    task automatic wait_switch_req(input string name);
        int k;
        k = 0;
        while (!bus.switch_req && k < 100) begin step(); k++; end
        chk(name, bus.switch_req, 1);
    endtask

    initial begin
        int k, sc0, pulses;
        bus.start = 0; bus.num_procs = 0; bus.instr_tick = 0; bus.io_req = 0;
        bus.io_done = 0; bus.io_pid = 0; bus.proc_exit = 0;
        #1 reset = 1'b1;
        step(); step();
        chk("rst_cur_pid", bus.cur_pid, 0);
        chk("rst_next_pid", bus.next_pid, 0);
        chk("rst_switch_req", bus.switch_req, 0);
        chk("rst_running", bus.running, 0);
        chk("rst_quantum", bus.quantum_left, 0);
        chk("rst_all_done", bus.all_done, 0);
        chk("rst_switch_count", bus.switch_count, 0);
        reset = 1'b0; step();

        // num_procs = 0 is ignored.
        start_procs(0); step(); step();
        chk("zero_procs_idle", {bus.running, bus.switch_req}, 0);

        // Three processes, full slices: order 0,1,2,0 with quantum reloaded to 8.
        do_reset();
        start_procs(3);
        bus.instr_tick = 1'b1;
        k = 0;
        while (dut_order.size() < 4 && k < 200) begin step(); k++; end
        step();
        bus.instr_tick = 1'b0;
        chk("order_len", dut_order.size() >= 4, 1);
        if (dut_order.size() >= 4 && m_order.size() >= 4 && q_after.size() >= 4) begin
            chk("order0", dut_order[0], 0); chk("order1", dut_order[1], 1);
            chk("order2", dut_order[2], 2); chk("order3", dut_order[3], 0);
            chk("model_order1", m_order[1], 1); chk("model_order3", m_order[3], 0);
            chk("reload0", q_after[0], 8); chk("reload3", q_after[3], 8);
        end
        `ifndef SCHED_STATS_EN
        chk("count_off", bus.switch_count, 0);
        `endif

        // num_procs above NPROC clamps; let the rotation run under the model.
        do_reset();
        start_procs(9);
        ticks(120);

        // pid0 blocks at its third tick, pid1 runs, pid0 wakes and follows pid1.
        do_reset();
        start_procs(2);
        wait_running("run_pid0");
        ticks(2);
        bus.io_req = 1'b1; bus.instr_tick = 1'b1; step(); bus.io_req = 1'b0; bus.instr_tick = 1'b0;
        wait_running("run_pid1");
        chk("cur_is_pid1", bus.cur_pid, 1);
        bus.io_done = 1'b1; bus.io_pid = 3'd0; step(); bus.io_done = 1'b0;
        ticks(8);
        wait_switch_req("req_back_to0");
        chk("next_is_pid0", bus.next_pid, 0);

        // Single process: expiry reloads the slice without a switch.
        do_reset();
        start_procs(1);
        wait_running("run_single");
        sc0 = int'(bus.switch_count);
        ticks(8);
        chk("single_sel_noreq", bus.switch_req, 0);
        step();
        chk("single_running", bus.running, 1);
        chk("single_reload", bus.quantum_left, 8);
        chk("single_noreq", bus.switch_req, 0);
        chk("single_count", bus.switch_count, sc0);

        // Both processes blocked: WAIT_IO until pid1 completes I/O.
        do_reset();
        start_procs(2);
        wait_running("blk_run0");
        bus.io_req = 1'b1; step(); bus.io_req = 1'b0;
        wait_running("blk_run1");
        bus.io_req = 1'b1; step(); bus.io_req = 1'b0;
        step();
        chk("wait_running_low", bus.running, 0);
        bus.start = 1'b1; bus.num_procs = 4'd4; step(); bus.start = 1'b0;
        bus.io_done = 1'b1; bus.io_pid = 3'd3; step(); bus.io_done = 1'b0;
        chk("wait_still", bus.switch_req, 0);
        bus.io_done = 1'b1; bus.io_pid = 3'd1; step(); bus.io_done = 1'b0;
        chk("wake_select_noreq", bus.switch_req, 0);
        step();
        chk("wake_switch_req", bus.switch_req, 1);
        chk("wake_next_pid", bus.next_pid, 1);

        // Exit wins over io_req and the final tick; all exit -> single all_done pulse.
        do_reset();
        start_procs(2);
        for (int r = 0; r < 2; r++) begin
            wait_running("exit_run");
            ticks(7);
            bus.proc_exit = 1'b1; bus.io_req = 1'b1; bus.instr_tick = 1'b1; step();
            bus.proc_exit = 1'b0; bus.io_req = 1'b0; bus.instr_tick = 1'b0;
        end
        pulses = 0;
        repeat (6) begin step(); if (bus.all_done) pulses++; end
        chk("all_done_pulses", pulses, 1);
        chk("done_idle", {bus.running, bus.switch_req}, 0);

        // Reset in the middle of a pending switch.
        do_reset();
        ack_en = 0;
        start_procs(3);
        wait_switch_req("pre_reset_req");
        reset = 1'b1; #1;
        chk("mid_rst_req", bus.switch_req, 0);
        chk("mid_rst_next", bus.next_pid, 0);
        chk("mid_rst_quantum", bus.quantum_left, 0);
        chk("mid_rst_running", bus.running, 0);
        step(); reset = 1'b0;
        step(); step(); step();
        chk("after_rst_idle", {bus.running, bus.switch_req}, 0);
        ack_en = 1;
        start_procs(2);
        wait_running("restart_run");
        chk("restart_cur", bus.cur_pid, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/process_scheduler.md
PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 SHALL have parameter NPROC, default 4, number of process slots (2..8).
REQ-002 SHALL have parameter QUANTUM, default 8, instructions per time slice (1..255).
REQ-003 SHALL have ports: clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high.
REQ-005 SHALL have ports: start  input  1  pulse; begin scheduling num_procs processes.
REQ-006 SHALL have ports: num_procs  input  4  process count latched on start.
REQ-007 SHALL have ports: instr_tick  input  1  one instruction of current process retired.
REQ-008 SHALL have ports: io_req  input  1  current process issued IN; block it.
REQ-009 SHALL have ports: io_done  input  1  debounced button pulse; I/O for io_pid complete.
REQ-010 SHALL have ports: io_pid  input  3  process whose I/O completed.
REQ-011 SHALL have ports: proc_exit  input  1  current process reached its end.
REQ-012 SHALL have ports: switch_ack  input  1  CPU finished saving/restoring context.
REQ-013 SHALL have ports: switch_req  output  1  request context switch to next_pid; level.
REQ-014 SHALL have ports: next_pid  output  3  target of pending switch.
REQ-015 SHALL have ports: cur_pid  output  3  process currently owning the CPU.
REQ-016 SHALL have ports: running  output  1  high in RUN state only.
REQ-017 SHALL have ports: quantum_left  output  8  remaining ticks in current slice.
REQ-018 SHALL have ports: all_done  output  1  one-cycle pulse when every process has exited.
REQ-019 SHALL have ports: switch_count  output  16  context switches since start.

Function
REQ-020 SHALL keep per-slot state EMPTY/READY/BLOCKED/EXITED; FSM states IDLE, SELECT, SWITCH, RUN, WAIT_IO, DONE.
REQ-021 IDLE+start: num_procs=0 ignored; values >NPROC clamped to NPROC; slots 0..n-1 READY, rest EMPTY; last_pid=NPROC-1; go SELECT.
REQ-022 SELECT (1 cycle): rotating search from last_pid+1 mod NPROC for READY; found -> next_pid, SWITCH; none READY and any BLOCKED -> WAIT_IO; none -> DONE.
REQ-023 If selected pid equals cur_pid after quantum expiry, SHALL skip SWITCH, reload quantum, enter RUN directly, no switch_req.
REQ-024 SWITCH: switch_req high until switch_ack sampled high; that edge sets cur_pid=last_pid=next_pid, quantum_left=QUANTUM, drops switch_req, enters RUN.
REQ-025 RUN: instr_tick decrements quantum_left; tick taking it to 0 -> slot stays READY, go SELECT.
REQ-026 RUN priority in same cycle: proc_exit (slot EXITED) > io_req (slot BLOCKED) > quantum expiry; each -> SELECT; tick ignored when exit/io_req present.
REQ-027 io_done in any non-IDLE state SHALL set slot io_pid READY only if BLOCKED; otherwise ignored; same-cycle with io_req on same pid leaves it BLOCKED.
REQ-028 WAIT_IO: running low; valid io_done -> SELECT next cycle.
REQ-029 DONE: all_done pulses one cycle; next cycle IDLE; start while not IDLE ignored.
REQ-030 Inputs instr_tick, io_req, proc_exit SHALL be ignored outside RUN; switch_ack ignored outside SWITCH.

Reset
REQ-031 Reset SHALL force IDLE, all slots EMPTY, cur_pid=0, next_pid=0, quantum_left=0, switch_req=0, running=0, all_done=0, switch_count=0, last_pid=NPROC-1, including mid-SWITCH.

Configuration
REQ-032 With SCHED_STATS_EN defined, switch_count SHALL increment (saturating at 0xFFFF) on each switch_ack accepted in SWITCH and clear on start.
REQ-033 Without SCHED_STATS_EN, switch_count SHALL be constant 0 and no counter logic exist.

Structure
REQ-034 Package sched_pkg SHALL hold FSM state enum, slot-state enum, PID_W=3, default NPROC/QUANTUM constants.
REQ-035 Sub-module rr_picker SHALL implement the combinational rotating READY search (inputs ready mask, last_pid; outputs found, pid).

Verification
REQ-036 Reset, start num_procs=3, ack each switch after 2 cycles, 8 ticks each -> switch order 0,1,2,0; quantum_left reloads 8.
REQ-037 num_procs=2, pid0 io_req at tick 3 -> pid1 runs; io_done io_pid=0 during pid1 -> after pid1 expiry pid0 selected.
REQ-038 num_procs=1, quantum expiry -> no switch_req, quantum_left=8 next cycle, switch_count unchanged.
REQ-039 Both of 2 processes blocked -> WAIT_IO, running=0; io_done io_pid=1 -> SELECT then switch_req next_pid=1.
REQ-040 proc_exit+io_req+final tick same cycle -> slot EXITED; all processes exit -> all_done one pulse, IDLE.
REQ-041 Reset asserted while switch_req high -> all outputs at reset values immediately, start required to resume.
